// File: rtl/dram_port_arbiter.sv
// dram_port_arbiter: round-robin two-requester arbiter onto a 64 x DATA_W distributed RAM (one RAM64X1D-style bit slice per data bit), with clear-on-reset sequencer, async monitor read port and busy flag
module dram_port_arbiter #(
  parameter int DATA_W = 2,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [5:0]        req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              req0_rvalid,
  output logic [DATA_W-1:0] req0_rdata,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [5:0]        req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              req1_rvalid,
  output logic [DATA_W-1:0] req1_rdata,
  input  logic [5:0]        mon_addr,
  output logic [DATA_W-1:0] mon_data,
  output logic              busy
);
  typedef enum logic {CLEAR, RUN} state_t;
  state_t r_state;
  logic [5:0] r_clr_addr;
  logic r_last;
  logic w_run, w_clr, w_g0, w_g1, w_we;
  logic [5:0] w_a;
  logic [DATA_W-1:0] w_d, w_spo;
  always_comb begin
    w_run = (r_state == RUN) && !rst;
    w_clr = (r_state == CLEAR) && !rst;
    w_g0 = w_run && req0_valid && (!req1_valid || r_last);
    w_g1 = w_run && req1_valid && (!req0_valid || !r_last);
    w_a = w_clr ? r_clr_addr : w_g0 ? req0_addr : w_g1 ? req1_addr : 6'd0;
    w_d = w_clr ? INIT_VALUE : w_g0 ? req0_wdata : w_g1 ? req1_wdata : '0;
    w_we = w_clr || (w_g0 && req0_we) || (w_g1 && req1_we);
    req0_ready = w_g0;
    req1_ready = w_g1;
    busy = rst || (r_state == CLEAR);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= CLEAR;
      r_clr_addr <= '0;
      r_last <= 1'b1;
      req0_rvalid <= 1'b0;
      req1_rvalid <= 1'b0;
      req0_rdata <= '0;
      req1_rdata <= '0;
    end else begin
      r_state <= (r_state == CLEAR && r_clr_addr == 6'd63) ? RUN : r_state;
      r_clr_addr <= (r_state == CLEAR) ? r_clr_addr + 6'd1 : r_clr_addr;
      r_last <= w_g0 ? 1'b0 : w_g1 ? 1'b1 : r_last;
      req0_rvalid <= w_g0 && !req0_we;
      req1_rvalid <= w_g1 && !req1_we;
      req0_rdata <= (w_g0 && !req0_we) ? w_spo : req0_rdata;
      req1_rdata <= (w_g1 && !req1_we) ? w_spo : req1_rdata;
    end
  end
  genvar b;
  generate
    for (b = 0; b < DATA_W; b++) begin : g_bit
      logic [63:0] r_ram;
      always_ff @(posedge clk) begin
        if (w_we) r_ram[w_a] <= w_d[b];
      end
      assign w_spo[b] = r_ram[w_a];
      assign mon_data[b] = r_ram[mon_addr];
    end
  endgenerate
endmodule

// File: tb/tb_dram_port_arbiter.sv
// tb_dram_port_arbiter: directed self-checking bench for dram_port_arbiter
module tb_dram_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0_valid = 1'b0, req0_we = 1'b0, req1_valid = 1'b0, req1_we = 1'b0;
  logic [5:0] req0_addr = '0, req1_addr = '0, mon_addr = '0;
  logic [1:0] req0_wdata = '0, req1_wdata = '0;
  logic req0_ready, req0_rvalid, req1_ready, req1_rvalid, busy;
  logic [1:0] req0_rdata, req1_rdata, mon_data;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  dram_port_arbiter #(.DATA_W(2), .INIT_VALUE(2'b10)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_ready(req0_ready), .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_ready(req1_ready), .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata),
    .mon_addr(mon_addr), .mon_data(mon_data), .busy(busy)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    tick();
    checks++;
    if ({busy, req0_ready, req1_ready, req0_rvalid, req1_rvalid, req0_rdata, req1_rdata} !== 9'b1_0000_0000) begin
      errors++;
      $display("FAIL reset_values busy=%b rdy=%b%b rv=%b%b rd=%b/%b expected busy=1 rest 0", busy, req0_ready, req1_ready, req0_rvalid, req1_rvalid, req0_rdata, req1_rdata);
    end
    rst = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (busy !== 1'b1 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++;
        $display("FAIL clear_busy cycle=%0d busy=%b ready=%b%b expected busy=1 ready=00", i, busy, req0_ready, req1_ready);
      end
      tick();
    end
    checks++;
    if (busy !== 1'b0 || req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL clear_done busy=%b ready=%b%b expected busy=0 ready=10", busy, req0_ready, req1_ready);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int i = 0; i < 64; i++) begin
      mon_addr = 6'(i);
      #1;
      checks++;
      if (mon_data !== 2'b10) begin
        errors++;
        $display("FAIL clear_mon addr=%0d got=%b expected=10", i, mon_data);
      end
    end
  endtask
  task automatic test_write_read;
    tick();
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 6'd5; req0_wdata = 2'b01; mon_addr = 6'd5;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || mon_data !== 2'b10) begin
      errors++;
      $display("FAIL wr_grant ready=%b mon=%b expected ready=1 mon=10", req0_ready, mon_data);
    end
    tick();
    req0_we = 1'b0;
    checks++;
    if (mon_data !== 2'b01 || req0_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL wr_mon mon=%b rvalid=%b expected mon=01 rvalid=0", mon_data, req0_rvalid);
    end
    tick();
    req0_valid = 1'b0;
    checks++;
    if (req0_rvalid !== 1'b1 || req0_rdata !== 2'b01) begin
      errors++;
      $display("FAIL rd_resp rvalid=%b rdata=%b expected rvalid=1 rdata=01", req0_rvalid, req0_rdata);
    end
    tick();
    checks++;
    if (req0_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rd_pulse rvalid=%b expected 0", req0_rvalid);
    end
  endtask
  task automatic test_fairness;
    req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 6'd10; req1_wdata = 2'b01;
    #1;
    checks++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      errors++;
      $display("FAIL fair_solo ready=%b%b expected 01", req0_ready, req1_ready);
    end
    tick();
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 6'd1; req0_wdata = 2'b01;
    req1_addr = 6'd2; req1_wdata = 2'b11;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL fair_first ready=%b%b expected 10", req0_ready, req1_ready);
    end
  endtask
  task automatic test_contention;
    logic [1:0] d0 [3];
    logic [1:0] d1 [3];
    int n0, n1;
    d0 = '{2'b01, 2'b11, 2'b00};
    d1 = '{2'b11, 2'b00, 2'b01};
    n0 = 0;
    n1 = 0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin
        errors++;
        $display("FAIL contention cycle=%0d ready=%b%b expected %b%b", i, req0_ready, req1_ready, i % 2 == 0, i % 2 == 1);
      end
      tick();
      if (i % 2 == 0) begin
        n0++;
        req0_wdata = d0[n0 % 3];
      end else begin
        n1++;
        req1_wdata = d1[n1 % 3];
      end
      #1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    mon_addr = 6'd1;
    #1;
    checks++;
    if (mon_data !== 2'b00) begin
      errors++;
      $display("FAIL cont_mem0 got=%b expected=00", mon_data);
    end
    mon_addr = 6'd2;
    #1;
    checks++;
    if (mon_data !== 2'b01) begin
      errors++;
      $display("FAIL cont_mem1 got=%b expected=01", mon_data);
    end
  endtask
  task automatic test_reset_during_read;
    int cnt;
    tick();
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 6'd2;
    tick();
    req1_valid = 1'b0;
    checks++;
    if (req1_rvalid !== 1'b1 || req1_rdata !== 2'b01) begin
      errors++;
      $display("FAIL rstrd_resp rvalid=%b rdata=%b expected 1/01", req1_rvalid, req1_rdata);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mon_addr = 6'd1;
    #1;
    checks++;
    if (req1_rvalid !== 1'b0 || req1_rdata !== 2'b00 || busy !== 1'b1 || mon_data !== 2'b00) begin
      errors++;
      $display("FAIL rstrd_kill rvalid=%b rdata=%b busy=%b mon1=%b expected 0/00/1/00", req1_rvalid, req1_rdata, busy, mon_data);
    end
    tick();
    checks++;
    if (mon_data !== 2'b00) begin
      errors++;
      $display("FAIL rstrd_order1 mon1=%b expected=00", mon_data);
    end
    tick();
    checks++;
    if (mon_data !== 2'b10) begin
      errors++;
      $display("FAIL rstrd_order2 mon1=%b expected=10", mon_data);
    end
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      tick();
      cnt++;
    end
    checks++;
    if (cnt !== 62) begin
      errors++;
      $display("FAIL rstrd_len remaining_busy=%0d expected=62", cnt);
    end
    for (int i = 0; i < 64; i++) begin
      mon_addr = 6'(i);
      #1;
      checks++;
      if (mon_data !== 2'b10) begin
        errors++;
        $display("FAIL rstrd_mon addr=%0d got=%b expected=10", i, mon_data);
      end
    end
  endtask
  task automatic test_boundary;
    tick();
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 6'd0; req0_wdata = 2'b01;
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 6'd63; req1_wdata = 2'b11;
    tick();
    req1_valid = 1'b0;
    mon_addr = 6'd0;
    #1;
    checks++;
    if (mon_data !== 2'b01) begin
      errors++;
      $display("FAIL bnd_mon0 got=%b expected=01", mon_data);
    end
    mon_addr = 6'd63;
    #1;
    checks++;
    if (mon_data !== 2'b11) begin
      errors++;
      $display("FAIL bnd_mon63 got=%b expected=11", mon_data);
    end
    mon_addr = 6'd62;
    #1;
    checks++;
    if (mon_data !== 2'b10) begin
      errors++;
      $display("FAIL bnd_mon62 got=%b expected=10", mon_data);
    end
    mon_addr = 6'd31;
    #1;
    checks++;
    if (mon_data !== 2'b10) begin
      errors++;
      $display("FAIL bnd_mon31 got=%b expected=10", mon_data);
    end
    tick();
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 6'd63;
    tick();
    req0_valid = 1'b0;
    checks++;
    if (req0_rvalid !== 1'b1 || req0_rdata !== 2'b11) begin
      errors++;
      $display("FAIL bnd_rd63 rvalid=%b rdata=%b expected 1/11", req0_rvalid, req0_rdata);
    end
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 6'd0;
    tick();
    req1_valid = 1'b0;
    checks++;
    if (req1_rvalid !== 1'b1 || req1_rdata !== 2'b01 || req0_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL bnd_rd0 rvalid1=%b rdata1=%b rvalid0=%b expected 1/01/0", req1_rvalid, req1_rdata, req0_rvalid);
    end
  endtask
  initial begin
    test_reset();
    test_write_read();
    test_fairness();
    test_contention();
    test_reset_during_read();
    test_boundary();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dram_port_arbiter.md
# dram_port_arbiter

Arbitrates two requesters onto one shared 64-deep distributed-RAM bank built from RAM64X1D primitives, one primitive per data bit. The shared read/write port (A/D/WE/SPO) is granted by round-robin. The dual-port read port (DPRA/DPO) is dedicated to an always-available monitor. After every reset a clear sequencer writes `INIT_VALUE` to all 64 words before any request is accepted. The block sits between board-level test logic (switch or UART-driven requesters) and the DRAM bank in xc7 distributed-RAM tests.

## Interface
- `DATA_W`, default 2: data width; one RAM64X1D per bit, range 1–16.
- `INIT_VALUE`, default 0: `DATA_W`-bit word written to every address during the clear sequence.
- `clk` in 1: single clock; drives all registers and RAM `WCLK`.
- `rst` in 1: reset, synchronous, active-high.
- `req0_valid` in 1: requester 0 has an operation pending.
- `req0_we` in 1: 1 = write, 0 = read.
- `req0_addr` in 6: word address.
- `req0_wdata` in `DATA_W`: write data.
- `req0_ready` out 1: grant. The operation is accepted on any edge where `valid & ready` is high.
- `req0_rvalid` out 1: one-cycle pulse carrying read data.
- `req0_rdata` out `DATA_W`: read data, valid while `req0_rvalid` is high.
- `req1_*`: same six signals for requester 1.
- `mon_addr` in 6: monitor read address, driven onto DPRA.
- `mon_data` out `DATA_W`: asynchronous DPO read of `mon_addr`.
- `busy` out 1: high during reset and the clear sequence.

## Operation
- States: CLEAR and RUN.
- CLEAR
  - Entered on any cycle with `rst` high.
  - A 6-bit counter `clr_addr` starts at 0. Each cycle the block writes `INIT_VALUE` at `clr_addr` and increments the counter.
  - After writing address 63 the state moves to RUN.
  - `busy` is 1 and both `ready` outputs are 0 throughout CLEAR.
- RUN, arbitration
  - A priority pointer `last` is reset to 1, so requester 0 wins the first contention.
  - Only `req0_valid`: grant 0. Only `req1_valid`: grant 1. Both valid: grant `!last`. Neither: no grant.
  - `reqN_ready` is combinational from the valid inputs and `last`. At most one ready is high in a cycle.
  - `last` updates to the granted index on every accepted transfer only; idle cycles leave it unchanged.
- Write
  - On an accepted write, shared-port A = `addr`, D = `wdata`, and WE = 1 for that edge.
  - Memory holds the new data after the edge.
- Read
  - On an accepted read, A = `addr` and WE = 0.
  - SPO is registered into `reqN_rdata` at the accept edge, and `reqN_rvalid` is 1 for exactly the next cycle.
- Idle shared port: A = 0, WE = 0.
- The requester must hold `valid`, `we`, `addr` and `wdata` stable until it is accepted. The arbiter never drops a held request.
- Monitor: `mon_data` = DPO(`mon_addr`), combinational. A write at address X is visible on `mon_data` from the cycle after the accept edge when `mon_addr` = X. During CLEAR the monitor shows partially cleared contents.
- Reset mid-operation
  - `rst` clears `rvalid` (an in-flight read response is lost), zeroes `rdata`, sets `last` to 1 and restarts CLEAR at address 0.
  - RAM contents are not preserved; they are overwritten by the clear.

## Timing
- Reset values: `req0_ready`/`req1_ready` 0, `req0_rvalid`/`req1_rvalid` 0, `req0_rdata`/`req1_rdata` 0, `busy` 1, `clr_addr` 0, `last` 1. `mon_data` tracks RAM contents and has no register.
- `rst` high at edge E0 and low afterwards: clear writes occur at edges E1..E64.
- After E64, `busy` = 0. The first grant can be accepted at edge E65.
- Write latency: data is in memory 1 edge after accept.
- Read latency: `rvalid` and `rdata` appear in the cycle after the accept edge, a one-cycle response.
- Throughput: one accepted operation per cycle in total. Under continuous contention each requester gets one accept every 2 cycles.
- Same-cycle write by one requester and read by the other cannot occur, because only one is granted.
- Read of an address written in the previous cycle returns the new data.

## Test plan
- Clear: `INIT_VALUE` = 2'b10; pulse `rst` for 1 cycle. Required: `busy` high for exactly 64 cycles after `rst` deasserts; `mon_data` = 2'b10 at all 64 addresses; no `ready` before E65.
- Write/read: req0 writes 2'b01 at addr 5, then reads addr 5. Required: `req0_rvalid` pulses 1 cycle after the read accept with `rdata` = 2'b01; `mon_addr`=5 shows 2'b01 one cycle after the write accept.
- Contention: both valid and held for 6 cycles, req0 writing addr 1 and req1 writing addr 2 (each requester then issues a new request). Required: grants alternate 0,1,0,1,0,1; never both ready in the same cycle.
- Fairness after idle: req1 alone is accepted once; then both become valid. Required: req0 is granted first.
- Reset during read: req1 read accepted at edge N, `rst` asserted at edge N+1. Required: `req1_rvalid` = 0 after N+1; CLEAR restarts at address 0; RAM fully rewritten to `INIT_VALUE`.
- Boundary: writes to addr 0 and addr 63 with distinct data, then reads via both the shared port and the monitor. Required: correct data at both ends, and no aliasing at addr 63.
